// File: rtl/glb_ld_dma_addr_gen.sv
// rtl/glb_ld_dma_addr_gen.sv - load-DMA read-request generator: header queue, nested loop addressing, duty cycle
module glb_ld_dma_addr_gen #(
  parameter int GLB_ADDR_WIDTH      = 22,
  parameter int LOOP_LEVEL          = 4,
  parameter int MAX_NUM_WORDS_WIDTH = 16,
  parameter int MAX_STRIDE_WIDTH    = 16,
  parameter int QUEUE_DEPTH         = 4
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        hdr_valid,
  output logic                                        hdr_ready,
  input  logic [GLB_ADDR_WIDTH-1:0]                   hdr_start_addr,
  input  logic [LOOP_LEVEL*MAX_NUM_WORDS_WIDTH-1:0]   hdr_range,
  input  logic [LOOP_LEVEL*MAX_STRIDE_WIDTH-1:0]      hdr_stride,
  input  logic [MAX_NUM_WORDS_WIDTH-1:0]              hdr_num_active,
  input  logic [MAX_NUM_WORDS_WIDTH-1:0]              hdr_num_inactive,
  input  logic                                        stall,
  input  logic                                        flush,
  output logic                                        rd_en,
  output logic [GLB_ADDR_WIDTH-1:0]                   rd_addr,
  output logic                                        busy,
  output logic                                        done_pulse
);

  localparam int AW = GLB_ADDR_WIDTH;
  localparam int NW = MAX_NUM_WORDS_WIDTH;
  localparam int SW = MAX_STRIDE_WIDTH;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [NW-1:0] ONE = NW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACTIVE,
    ST_INACTIVE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [AW-1:0]            r_q_start    [QUEUE_DEPTH];
  logic [LOOP_LEVEL*NW-1:0] r_q_range    [QUEUE_DEPTH];
  logic [LOOP_LEVEL*SW-1:0] r_q_stride   [QUEUE_DEPTH];
  logic [NW-1:0]            r_q_active   [QUEUE_DEPTH];
  logic [NW-1:0]            r_q_inactive [QUEUE_DEPTH];
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_count;

  logic [NW-1:0] r_range  [LOOP_LEVEL];
  logic [SW-1:0] r_stride [LOOP_LEVEL];
  logic [NW-1:0] r_itr    [LOOP_LEVEL];
  logic [AW-1:0] r_cur    [LOOP_LEVEL];
  logic [NW-1:0] r_num_active;
  logic [NW-1:0] r_num_inactive;
  logic [NW-1:0] r_burst_cnt;
  logic [NW-1:0] r_inact_cnt;
  logic          r_fin;
  logic          r_rd_en;
  logic [AW-1:0] r_rd_addr;
  logic          r_done;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_done;
  logic                  w_q_nonempty;
  logic [LOOP_LEVEL-1:0] w_at_max;
  logic [LOOP_LEVEL-1:0] w_inc;
  logic [LOOP_LEVEL-1:0] w_wrap;
  logic                  w_carry;
  logic                  w_last;
  logic                  w_burst_end;
  logic [AW-1:0]         w_new_addr;

  assign hdr_ready    = (r_count != CW'(QUEUE_DEPTH));
  assign w_q_nonempty = (r_count != '0);
  assign w_push       = hdr_valid && hdr_ready && !flush;
  assign busy         = (r_state != ST_IDLE) || w_q_nonempty;
  assign rd_en        = r_rd_en;
  assign rd_addr      = r_rd_addr;
  assign done_pulse   = r_done;
  assign w_burst_end  = (r_num_active != '0) && (r_burst_cnt == r_num_active - ONE);

  // r_cur[k] is the address with every level below k at index 0, so stepping
  // level k only needs one add and the lower levels restart from that sum.
  always_comb begin
    w_at_max   = '0;
    w_inc      = '0;
    w_wrap     = '0;
    w_new_addr = '0;
    w_carry    = 1'b1;
    for (int k = 0; k < LOOP_LEVEL; k++) begin
      w_at_max[k] = (r_range[k] == '0) || (r_itr[k] == r_range[k] - ONE);
      w_inc[k]    = w_carry && !w_at_max[k];
      w_wrap[k]   = w_carry && w_at_max[k];
      if (w_inc[k]) begin
        w_new_addr = r_cur[k] + AW'(r_stride[k]);
      end
      w_carry = w_carry && w_at_max[k];
    end
    w_last = w_carry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The issue decision samples stall and is loaded into the rd_en/rd_addr
  // registers, so a word shows on the outputs the cycle after it is chosen.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_issue      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_q_nonempty) begin
          w_pop        = 1'b1;
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_next_state = ST_ACTIVE;
        w_issue      = !stall;
      end
      ST_ACTIVE: begin
        if (r_fin) begin
          w_done = 1'b1;
          if (w_q_nonempty) begin
            w_pop        = 1'b1;
            w_next_state = ST_LOAD;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_issue = !stall;
        end
      end
      ST_INACTIVE: begin
        w_issue = !stall && (r_inact_cnt == r_num_inactive);
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (w_issue) begin
      if (!w_last && w_burst_end && (r_num_inactive != '0)) begin
        w_next_state = ST_INACTIVE;
      end else begin
        w_next_state = ST_ACTIVE;
      end
    end
    if (flush) begin
      w_next_state = ST_IDLE;
      w_pop        = 1'b0;
      w_issue      = 1'b0;
      w_done       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_start[r_wr_ptr]    <= hdr_start_addr;
      r_q_range[r_wr_ptr]    <= hdr_range;
      r_q_stride[r_wr_ptr]   <= hdr_stride;
      r_q_active[r_wr_ptr]   <= hdr_num_active;
      r_q_inactive[r_wr_ptr] <= hdr_num_inactive;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LOOP_LEVEL; k++) begin
        r_range[k]  <= '0;
        r_stride[k] <= '0;
        r_itr[k]    <= '0;
        r_cur[k]    <= '0;
      end
      r_num_active   <= '0;
      r_num_inactive <= '0;
      r_burst_cnt    <= '0;
      r_inact_cnt    <= '0;
      r_fin          <= 1'b0;
      r_rd_en        <= 1'b0;
      r_rd_addr      <= '0;
      r_done         <= 1'b0;
    end else begin
      r_rd_en <= w_issue;
      r_done  <= w_done;
      if (w_pop) begin
        for (int k = 0; k < LOOP_LEVEL; k++) begin
          r_range[k]  <= r_q_range[r_rd_ptr][k*NW +: NW];
          r_stride[k] <= r_q_stride[r_rd_ptr][k*SW +: SW];
          r_itr[k]    <= '0;
          r_cur[k]    <= r_q_start[r_rd_ptr];
        end
        r_num_active   <= r_q_active[r_rd_ptr];
        r_num_inactive <= r_q_inactive[r_rd_ptr];
        r_burst_cnt    <= '0;
        r_inact_cnt    <= '0;
        r_fin          <= 1'b0;
      end else if (w_issue) begin
        r_rd_addr <= r_cur[0];
        r_fin     <= w_last;
        if (!w_last) begin
          for (int k = 0; k < LOOP_LEVEL; k++) begin
            if (w_inc[k]) begin
              r_itr[k] <= r_itr[k] + ONE;
              r_cur[k] <= w_new_addr;
            end else if (w_wrap[k]) begin
              r_itr[k] <= '0;
              r_cur[k] <= w_new_addr;
            end
          end
        end
        if (w_burst_end) begin
          r_burst_cnt <= '0;
          r_inact_cnt <= '0;
        end else begin
          r_burst_cnt <= r_burst_cnt + ONE;
        end
      end else if ((r_state == ST_INACTIVE) && !stall && !flush) begin
        r_inact_cnt <= r_inact_cnt + ONE;
      end
    end
  end

endmodule

// File: tb/tb_glb_ld_dma_addr_gen.sv
// tb/tb_glb_ld_dma_addr_gen.sv - directed self-checking bench for glb_ld_dma_addr_gen
module tb_glb_ld_dma_addr_gen;

  localparam int AW = 22;
  localparam int L  = 4;
  localparam int NW = 16;
  localparam int SW = 16;
  localparam int QD = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            hdr_valid;
  logic            hdr_ready;
  logic [AW-1:0]   hdr_start_addr;
  logic [L*NW-1:0] hdr_range;
  logic [L*SW-1:0] hdr_stride;
  logic [NW-1:0]   hdr_num_active;
  logic [NW-1:0]   hdr_num_inactive;
  logic            stall;
  logic            flush;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic            busy;
  logic            done_pulse;

  always #5 clk = ~clk;

  glb_ld_dma_addr_gen #(
    .GLB_ADDR_WIDTH      (AW),
    .LOOP_LEVEL          (L),
    .MAX_NUM_WORDS_WIDTH (NW),
    .MAX_STRIDE_WIDTH    (SW),
    .QUEUE_DEPTH         (QD)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .hdr_valid        (hdr_valid),
    .hdr_ready        (hdr_ready),
    .hdr_start_addr   (hdr_start_addr),
    .hdr_range        (hdr_range),
    .hdr_stride       (hdr_stride),
    .hdr_num_active   (hdr_num_active),
    .hdr_num_inactive (hdr_num_inactive),
    .stall            (stall),
    .flush            (flush),
    .rd_en            (rd_en),
    .rd_addr          (rd_addr),
    .busy             (busy),
    .done_pulse       (done_pulse)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0]   cap_en;
  logic [63:0]   cap_done;
  logic [63:0]   cap_busy;
  logic [AW-1:0] cap_addr[$];
  logic [AW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_addrs(input string tag, input logic [AW-1:0] exp[$]);
    logic [63:0] obs;
    check($sformatf("%s_nwords", tag), 64'(cap_addr.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      obs = (i < cap_addr.size()) ? 64'(cap_addr[i]) : 64'hFFFF_FFFF_FFFF_FFFF;
      check($sformatf("%s_addr%0d", tag, i), obs, 64'(exp[i]));
    end
  endtask

  task automatic set_hdr(input logic [AW-1:0] start, input logic [NW-1:0] r0, input logic [SW-1:0] s0,
                         input logic [NW-1:0] r1, input logic [SW-1:0] s1,
                         input logic [NW-1:0] act, input logic [NW-1:0] inact);
    hdr_start_addr   = start;
    hdr_range        = {NW'(0), NW'(0), r1, r0};
    hdr_stride       = {SW'(0), SW'(0), s1, s0};
    hdr_num_active   = act;
    hdr_num_inactive = inact;
  endtask

  task automatic push_hdr(input logic [AW-1:0] start, input logic [NW-1:0] r0, input logic [SW-1:0] s0,
                          input logic [NW-1:0] r1, input logic [SW-1:0] s1,
                          input logic [NW-1:0] act, input logic [NW-1:0] inact);
    set_hdr(start, r0, s0, r1, s1, act, inact);
    hdr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hdr_valid = 1'b0;
  endtask

  // Bit i of each capture vector is the sample i+1 cycles after the call.
  task automatic capture(input int n, input int st_from, input int st_to);
    cap_en   = '0;
    cap_done = '0;
    cap_busy = '0;
    cap_addr.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_en[i]   = rd_en;
      cap_done[i] = done_pulse;
      cap_busy[i] = busy;
      if (rd_en) cap_addr.push_back(rd_addr);
      stall = (i >= st_from) && (i < st_to);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    hdr_valid = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    set_hdr('0, '0, '0, '0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_pulse, 0);
    check("rst_hdr_ready", hdr_ready, 1);
    reset = 1'b0;

    push_hdr(22'h100, 4, 8, 0, 0, 0, 0);
    check("t1_en_T", rd_en, 0);
    check("t1_busy_T", busy, 1);
    capture(7, 0, 0);
    check("t1_en", cap_en, 64'b0011110);
    check("t1_done", cap_done, 64'b0100000);
    check("t1_busy", cap_busy, 64'b0011111);
    exp_q = '{22'h100, 22'h108, 22'h110, 22'h118};
    check_addrs("t1", exp_q);

    push_hdr(22'h000, 2, 8, 3, 16'h40, 0, 0);
    capture(9, 0, 0);
    check("t2_en", cap_en, 64'h7E);
    check("t2_done", cap_done, 64'h80);
    exp_q = '{22'h000, 22'h008, 22'h040, 22'h048, 22'h080, 22'h088};
    check_addrs("t2", exp_q);

    push_hdr(22'h200, 6, 8, 0, 0, 2, 3);
    capture(15, 0, 0);
    check("t3_en", cap_en, 64'h18C6);
    check("t3_done", cap_done, 64'h2000);
    exp_q = '{22'h200, 22'h208, 22'h210, 22'h218, 22'h220, 22'h228};
    check_addrs("t3", exp_q);

    push_hdr(22'h100, 4, 8, 0, 0, 0, 0);
    capture(10, 2, 5);
    check("t4_en", cap_en, 64'hC6);
    check("t4_done", cap_done, 64'h100);
    exp_q = '{22'h100, 22'h108, 22'h110, 22'h118};
    check_addrs("t4", exp_q);

    stall = 1'b1;
    for (int h = 0; h < 6; h++) begin
      set_hdr(AW'((h + 1) * 4096), 2, 4, 0, 0, 0, 0);
      hdr_valid = 1'b1;
      check($sformatf("t5_ready%0d", h), hdr_ready, (h < 5) ? 1 : 0);
      @(posedge clk);
      @(negedge clk);
    end
    hdr_valid = 1'b0;
    check("t5_ready_full", hdr_ready, 0);
    check("t5_en_stalled", rd_en, 0);
    check("t5_busy_stalled", busy, 1);
    stall = 1'b0;
    capture(16, 0, 0);
    check("t5_en", cap_en, 64'h36DB);
    check("t5_done", cap_done, 64'h4924);
    check("t5_busy_end", cap_busy[15], 0);
    exp_q = '{22'h1000, 22'h1004, 22'h2000, 22'h2004, 22'h3000, 22'h3004,
              22'h4000, 22'h4004, 22'h5000, 22'h5004};
    check_addrs("t5", exp_q);

    push_hdr(22'h3FFFF8, 2, 8, 0, 0, 0, 0);
    capture(5, 0, 0);
    check("t6_en", cap_en, 64'h6);
    check("t6_done", cap_done, 64'h8);
    exp_q = '{22'h3FFFF8, 22'h000000};
    check_addrs("t6", exp_q);

    push_hdr(22'h500, 8, 4, 0, 0, 0, 0);
    push_hdr(22'h600, 2, 4, 0, 0, 0, 0);
    push_hdr(22'h700, 2, 4, 0, 0, 0, 0);
    check("t7_running_en", rd_en, 1);
    check("t7_running_addr", rd_addr, 22'h500);
    set_hdr(22'h800, 2, 4, 0, 0, 0, 0);
    hdr_valid = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush     = 1'b0;
    hdr_valid = 1'b0;
    check("t7_flush_en", rd_en, 0);
    check("t7_flush_busy", busy, 0);
    check("t7_flush_done", done_pulse, 0);
    check("t7_flush_ready", hdr_ready, 1);
    capture(4, 0, 0);
    check("t7_after_en", cap_en, 0);
    check("t7_after_done", cap_done, 0);
    check("t7_after_busy", cap_busy, 0);

    push_hdr(22'h500, 8, 4, 0, 0, 0, 0);
    push_hdr(22'h600, 2, 4, 0, 0, 0, 0);
    @(negedge clk);
    check("t8_running_en", rd_en, 1);
    reset = 1'b1;
    #1;
    check("t8_rst_en", rd_en, 0);
    check("t8_rst_addr", rd_addr, 0);
    check("t8_rst_busy", busy, 0);
    check("t8_rst_done", done_pulse, 0);
    check("t8_rst_ready", hdr_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    capture(4, 0, 0);
    check("t8_after_en", cap_en, 0);
    check("t8_after_done", cap_done, 0);

    push_hdr(22'h040, 1, 0, 0, 0, 0, 0);
    capture(3, 0, 0);
    check("t9_en", cap_en, 64'b010);
    check("t9_done", cap_done, 64'b100);
    exp_q = '{22'h040};
    check_addrs("t9", exp_q);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
